// File: rtl/ada_pkg.sv
// Shared constants and types for the ada integer register file.
package ada_pkg;

  localparam int unsigned ADA_REG_DATA_W = 32;
  localparam int unsigned ADA_REG_ADDR_W = 5;

  typedef logic [ADA_REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [ADA_REG_DATA_W-1:0] word_t;

  localparam reg_addr_t ADA_ZERO_REG = 5'd0;

endpackage

// File: rtl/ada_regfile_2r1w_if.sv
// Operand-fetch / writeback bus of the ada register file.
// The master drives addresses and write data; the slave (register file) returns read data.
interface ada_regfile_2r1w_if
  import ada_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADA_REG_DATA_W,
  parameter int unsigned ADDR_WIDTH = ADA_REG_ADDR_W
) ();

  logic [ADDR_WIDTH-1:0] read_addr_a;
  logic [ADDR_WIDTH-1:0] read_addr_b;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  we;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic [DATA_WIDTH-1:0] read_data_b;

  modport master (
    output read_addr_a, read_addr_b, write_addr, write_data, we,
    input  read_data_a, read_data_b
  );

  modport slave (
    input  read_addr_a, read_addr_b, write_addr, write_data, we,
    output read_data_a, read_data_b
  );

endinterface

// File: rtl/ada_rf_read_port.sv
// One combinational read port: 2**ADDR_WIDTH:1 mux, zero-register masking and, when
// ADA_RF_BYPASS_EN is defined, same-cycle forwarding of the write port.
module ada_rf_read_port
  import ada_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADA_REG_DATA_W,
  parameter int unsigned ADDR_WIDTH = ADA_REG_ADDR_W
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] i_regs,
  input  logic [ADDR_WIDTH-1:0]                    i_addr,
  input  logic                                     i_we,
  input  logic                                     i_rst,
  input  logic [ADDR_WIDTH-1:0]                    i_waddr,
  input  logic [DATA_WIDTH-1:0]                    i_wdata,
  output logic [DATA_WIDTH-1:0]                    o_data
);

  logic [DATA_WIDTH-1:0] w_data;

  always_comb begin
    w_data = i_regs[i_addr];
`ifdef ADA_RF_BYPASS_EN
    if (i_we && !i_rst && (i_waddr == i_addr)) begin
      w_data = i_wdata;
    end
`endif
    // Masking last also blocks forwarding of writes aimed at register 0.
    if (i_addr == ADDR_WIDTH'(ADA_ZERO_REG)) begin
      w_data = '0;
    end
  end

`ifndef ADA_RF_BYPASS_EN
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_we, i_rst, i_waddr, i_wdata};
`endif

  assign o_data = w_data;

endmodule

// File: rtl/ada_regfile_2r1w.sv
// 2-read/1-write flop-based integer register file, register 0 hardwired to zero.
// Optional same-cycle write forwarding with `define ADA_RF_BYPASS_EN.
module ada_regfile_2r1w
  import ada_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADA_REG_DATA_W,
  parameter int unsigned ADDR_WIDTH = ADA_REG_ADDR_W
) (
  input logic                clk,
  input logic                rst,
  ada_regfile_2r1w_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_regs;

  assign w_regs[0] = '0;

  // Only entries 1..DEPTH-1 have storage.
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic                  w_wr_sel;
    logic [DATA_WIDTH-1:0] r_q;

    assign w_wr_sel = bus.we && (bus.write_addr == ADDR_WIDTH'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_wr_sel) begin
        r_q <= bus.write_data;
      end
    end

    assign w_regs[i] = r_q;
  end

  ada_rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_a (
    .i_regs  (w_regs),
    .i_addr  (bus.read_addr_a),
    .i_we    (bus.we),
    .i_rst   (rst),
    .i_waddr (bus.write_addr),
    .i_wdata (bus.write_data),
    .o_data  (bus.read_data_a)
  );

  ada_rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_b (
    .i_regs  (w_regs),
    .i_addr  (bus.read_addr_b),
    .i_we    (bus.we),
    .i_rst   (rst),
    .i_waddr (bus.write_addr),
    .i_wdata (bus.write_data),
    .o_data  (bus.read_data_b)
  );

endmodule

// File: tb/tb_ada_regfile_2r1w.sv
// Directed self-checking bench for ada_regfile_2r1w (honours ADA_RF_BYPASS_EN).
module tb_ada_regfile_2r1w;
  import ada_pkg::*;

  logic  clk;
  logic  rst;
  word_t model [32];
  int    n_cmp;
  int    n_err;

  ada_regfile_2r1w_if #(
    .DATA_WIDTH (ADA_REG_DATA_W),
    .ADDR_WIDTH (ADA_REG_ADDR_W)
  ) u_if ();

  ada_regfile_2r1w #(
    .DATA_WIDTH (ADA_REG_DATA_W),
    .ADDR_WIDTH (ADA_REG_ADDR_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 32; i++) begin
      u_if.read_addr_a = reg_addr_t'(i);
      u_if.read_addr_b = reg_addr_t'(31 - i);
      #1;
      n_cmp++;
      if (u_if.read_data_a !== 32'h0) begin
        n_err++;
        $display("FAIL reset_a[%0d]: got %h want %h", i, u_if.read_data_a, 32'h0);
      end
      n_cmp++;
      if (u_if.read_data_b !== 32'h0) begin
        n_err++;
        $display("FAIL reset_b[%0d]: got %h want %h", 31 - i, u_if.read_data_b, 32'h0);
      end
    end
  endtask

  task automatic test_fill_read();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      u_if.we         = 1'b1;
      u_if.write_addr = reg_addr_t'(i);
      u_if.write_data = $urandom;
      model[i]        = u_if.write_data;
    end
    @(negedge clk);
    u_if.we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      u_if.read_addr_a = reg_addr_t'(i);
      #1;
      n_cmp++;
      if (u_if.read_data_a !== model[i]) begin
        n_err++;
        $display("FAIL fill_a[%0d]: got %h want %h", i, u_if.read_data_a, model[i]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      u_if.read_addr_b = reg_addr_t'(i);
      #1;
      n_cmp++;
      if (u_if.read_data_b !== model[i]) begin
        n_err++;
        $display("FAIL fill_b[%0d]: got %h want %h", i, u_if.read_data_b, model[i]);
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    u_if.we          = 1'b1;
    u_if.write_addr  = 5'd0;
    u_if.write_data  = 32'hDEADBEEF;
    u_if.read_addr_a = 5'd0;
    u_if.read_addr_b = 5'd0;
    #1;
    n_cmp++;
    if (u_if.read_data_a !== 32'h0) begin
      n_err++;
      $display("FAIL zero_same_cycle_a: got %h want %h", u_if.read_data_a, 32'h0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (u_if.read_data_a !== 32'h0) begin
      n_err++;
      $display("FAIL zero_a: got %h want %h", u_if.read_data_a, 32'h0);
    end
    n_cmp++;
    if (u_if.read_data_b !== 32'h0) begin
      n_err++;
      $display("FAIL zero_b: got %h want %h", u_if.read_data_b, 32'h0);
    end
    @(negedge clk);
    u_if.we = 1'b0;
  endtask

  task automatic test_we_gating();
    @(negedge clk);
    u_if.we          = 1'b0;
    u_if.write_addr  = 5'd7;
    u_if.write_data  = 32'h12345678;
    u_if.read_addr_a = 5'd7;
    @(posedge clk);
    #1;
    n_cmp++;
    if (u_if.read_data_a !== model[7]) begin
      n_err++;
      $display("FAIL we_gating: got %h want %h", u_if.read_data_a, model[7]);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    u_if.we         = 1'b1;
    u_if.write_addr = 5'd9;
    u_if.write_data = 32'hAAAA0000;
    @(negedge clk);
    u_if.write_data  = 32'h5555FFFF;
    u_if.read_addr_a = 5'd9;
    u_if.read_addr_b = 5'd9;
    #1;
`ifdef ADA_RF_BYPASS_EN
    n_cmp++;
    if (u_if.read_data_a !== 32'h5555FFFF) begin
      n_err++;
      $display("FAIL rdw_before_edge_a: got %h want %h", u_if.read_data_a, 32'h5555FFFF);
    end
`else
    n_cmp++;
    if (u_if.read_data_a !== 32'hAAAA0000) begin
      n_err++;
      $display("FAIL rdw_before_edge_a: got %h want %h", u_if.read_data_a, 32'hAAAA0000);
    end
`endif
    @(posedge clk);
    #1;
    model[9] = 32'h5555FFFF;
    n_cmp++;
    if (u_if.read_data_a !== 32'h5555FFFF) begin
      n_err++;
      $display("FAIL rdw_after_edge_a: got %h want %h", u_if.read_data_a, 32'h5555FFFF);
    end
    n_cmp++;
    if (u_if.read_data_b !== 32'h5555FFFF) begin
      n_err++;
      $display("FAIL rdw_after_edge_b: got %h want %h", u_if.read_data_b, 32'h5555FFFF);
    end
    @(negedge clk);
    u_if.we          = 1'b0;
    u_if.read_addr_b = 5'd31;
    #1;
    n_cmp++;
    if (u_if.read_data_b !== model[31]) begin
      n_err++;
      $display("FAIL independent_b: got %h want %h", u_if.read_data_b, model[31]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    u_if.we          = 1'b1;
    u_if.write_addr  = 5'd3;
    u_if.write_data  = 32'hCAFEF00D;
    u_if.read_addr_a = 5'd3;
    u_if.read_addr_b = 5'd9;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (u_if.read_data_a !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst_a: got %h want %h", u_if.read_data_a, 32'h0);
    end
    n_cmp++;
    if (u_if.read_data_b !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst_b: got %h want %h", u_if.read_data_b, 32'h0);
    end
    #1;
    rst     = 1'b0;
    u_if.we = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (u_if.read_data_a !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst_after_edge: got %h want %h", u_if.read_data_a, 32'h0);
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    rst              = 1'b0;
    u_if.we          = 1'b0;
    u_if.write_addr  = '0;
    u_if.write_data  = '0;
    u_if.read_addr_a = '0;
    u_if.read_addr_b = '0;
    test_reset();
    test_fill_read();
    test_zero_reg();
    test_we_gating();
    test_read_during_write();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
